// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the sequential multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    localparam int          MDU_ITER     = 32;
    localparam int          MDU_LATENCY  = 34;
    localparam int          MDU_CNT_W    = 5;
    localparam logic [31:0] MDU_DIV0_QUO = 32'hFFFFFFFF;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitude pre-conditioning and result sign post-fix
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_unsigned,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_unsigned,
    input  logic        op_mult,
    input  logic        op_div_zero,
    input  logic [63:0] raw,
    output logic [63:0] fixed
);

    logic        neg_res;
    logic        neg_rem;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        mag_a = (!in_unsigned && in_a[31]) ? (~in_a + 32'd1) : in_a;
        mag_b = (!in_unsigned && in_b[31]) ? (~in_b + 32'd1) : in_b;
    end

    // raw holds {hi, lo}: the unsigned product, or {remainder, quotient} of magnitudes
    always_comb begin
        neg_res = !op_unsigned && (op_a[31] ^ op_b[31]);
        neg_rem = !op_unsigned && op_a[31];
        quo     = neg_res ? (~raw[31:0] + 32'd1) : raw[31:0];
        rem     = neg_rem ? (~raw[63:32] + 32'd1) : raw[63:32];
        if (op_mult) begin
            fixed = neg_res ? (~raw + 64'd1) : raw;
        end else if (op_div_zero) begin
            fixed = {op_a, MDU_DIV0_QUO};
        end else begin
            fixed = {rem, quo};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - 32-cycle shift-add multiplier / restoring divider with fixed latency
// Divide hardware is present only when MULT_DIV_SEQ_DIV_EN is defined.
module mult_div_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_mult,
    input  logic        is_unsigned,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        div_by_zero
);

    mdu_state_t             state;
    mdu_state_t             state_next;
    logic [MDU_CNT_W-1:0]   cnt;
    logic [31:0]            op_a;
    logic [31:0]            op_b;
    logic                   op_mult;
    logic                   op_unsigned;
    logic                   dz_flag;
    logic [31:0]            opnd;
    logic [31:0]            acc;
    logic [31:0]            lo;
    logic [31:0]            mag_a;
    logic [31:0]            mag_b;
    logic [63:0]            fixed;
    logic                   div_zero;
    logic [32:0]            mul_sum;
`ifdef MULT_DIV_SEQ_DIV_EN
    logic [32:0]            div_shift;
    logic [32:0]            div_diff;
`endif

    assign div_zero = !op_mult && (op_b == 32'd0);

    mdu_sign_fix u_sign_fix (
        .in_a        (a),
        .in_b        (b),
        .in_unsigned (is_unsigned),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_unsigned (op_unsigned),
        .op_mult     (op_mult),
        .op_div_zero (div_zero),
        .raw         ({acc, lo}),
        .fixed       (fixed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MULT_DIV_SEQ_DIV_EN
                    state_next = S_CALC;
`else
                    state_next = is_mult ? S_CALC : S_DONE;
`endif
                end
            end
            S_CALC: begin
                if (cnt == MDU_CNT_W'(MDU_ITER - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy        = (state == S_CALC) || (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) && dz_flag;

    // product accumulates in {acc, lo} shifting right; divide shifts dividend left out of lo
    always_comb begin
        mul_sum = {1'b0, acc} + {1'b0, (lo[0] ? opnd : 32'd0)};
`ifdef MULT_DIV_SEQ_DIV_EN
        div_shift = {acc, lo[31]};
        div_diff  = div_shift - {1'b0, opnd};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_mult     <= 1'b0;
            op_unsigned <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
            lo          <= '0;
            result      <= '0;
            dz_flag     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a        <= a;
                        op_b        <= b;
                        op_mult     <= is_mult;
                        op_unsigned <= is_unsigned;
                        cnt         <= '0;
                        acc         <= '0;
                        lo          <= is_mult ? mag_b : mag_a;
                        opnd        <= is_mult ? mag_a : mag_b;
`ifndef MULT_DIV_SEQ_DIV_EN
                        if (!is_mult) begin
                            result  <= '0;
                            dz_flag <= 1'b0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
`ifdef MULT_DIV_SEQ_DIV_EN
                    if (op_mult) begin
                        acc <= mul_sum[32:1];
                        lo  <= {mul_sum[0], lo[31:1]};
                    end else if (!div_diff[32]) begin
                        acc <= div_diff[31:0];
                        lo  <= {lo[30:0], 1'b1};
                    end else begin
                        acc <= div_shift[31:0];
                        lo  <= {lo[30:0], 1'b0};
                    end
`else
                    acc <= mul_sum[32:1];
                    lo  <= {mul_sum[0], lo[31:1]};
`endif
                end
                S_FIX: begin
                    result  <= fixed;
                    dz_flag <= div_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - directed and randomized self-checking bench for mult_div_seq
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_mult;
    logic        is_unsigned;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mult_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_mult     (is_mult),
        .is_unsigned (is_unsigned),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Architectural reference: plain integer arithmetic on the operands
    function automatic logic [63:0] model(input logic m, input logic u, input logic [31:0] x,
                                          input logic [31:0] y, output logic dz, output int lat);
        longint sx;
        longint sy;
        longint q;
        longint r;
        dz  = 1'b0;
        lat = 34;
        if (m) begin
            if (u) return {32'd0, x} * {32'd0, y};
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
`ifdef MULT_DIV_SEQ_DIV_EN
        if (y == 32'd0) begin
            dz = 1'b1;
            return {x, 32'hFFFFFFFF};
        end
        if (u) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
`else
        lat = 1;
        return 64'd0;
`endif
    endfunction

    task automatic launch(input logic m, input logic u, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        is_mult     = m;
        is_unsigned = u;
        a           = x;
        b           = y;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic run_op(input string tag, input logic m, input logic u,
                          input logic [31:0] x, input logic [31:0] y);
        logic [63:0] want;
        logic        want_dz;
        int          lat;
        int          k;
        want = model(m, u, x, y, want_dz, lat);
        launch(m, u, x, y);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1 && lat > 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
        end while (!done && k < 40);
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_result"}, result, want);
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(want_dz));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'({done, div_by_zero}), 64'd0);
        chk({tag, "_held"}, result, want);
    endtask

    initial begin
        logic [63:0] want;
        logic        want_dz;
        int          lat;
        int          ndone;
        int          done_at;
        rst         = 1'b1;
        start       = 1'b0;
        is_mult     = 1'b0;
        is_unsigned = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, div_by_zero, result}, 67'd0);
        rst = 1'b0;

        run_op("smul_neg3x5", 1'b1, 1'b0, 32'hFFFFFFFD, 32'd5);
        run_op("umul_max", 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("sdiv_neg7_2", 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2);
        run_op("udiv_by0", 1'b0, 1'b1, 32'd7, 32'd0);
        run_op("sdiv_by0", 1'b0, 1'b0, 32'hFFFFFFF8, 32'd0);
        run_op("sdiv_ovf", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_op("smul_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000);

        // second start while busy must be ignored
        want = model(1'b1, 1'b0, 32'h00001234, 32'hFFFF0001, want_dz, lat);
        launch(1'b1, 1'b0, 32'h00001234, 32'hFFFF0001);
        ndone   = 0;
        done_at = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 5) begin
                is_mult = 1'b1;
                a       = 32'h7;
                b       = 32'h9;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                done_at = k;
                chk("busy_start_result", result, want);
            end
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_at", 64'(done_at), 64'd34);

        // reset mid-operation aborts without a done pulse
        launch(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", result, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op("after_abort", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000003);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            rx = $urandom;
            ry = $urandom;
            if (i % 6 == 5) ry = 32'd0;
            if (i % 7 == 3) ry = ry >> $urandom_range(31, 0);
            run_op($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), rx, ry);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, asynchronous, active-high; one clock domain only.
REQ-003 start  input  1  request strobe; sampled only in IDLE.
REQ-004 is_mult  input  1  1 = multiply, 0 = divide; captured with start.
REQ-005 is_unsigned  input  1  1 = unsigned operands; captured with start.
REQ-006 a  input  32  multiplicand / dividend (register rs); captured with start.
REQ-007 b  input  32  multiplier / divisor (register rt); captured with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result is valid that cycle.
REQ-010 result  output  64  {hi, lo}, fed to the Lo/Hi register write port; held between completions.
REQ-011 div_by_zero  output  1  pulses with done when a divide had b == 0.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE.
REQ-013 IDLE with start=1 at edge N SHALL latch operands and flags, clear the iteration counter, and enter CALC; busy=1 from cycle N+1.
REQ-014 CALC SHALL perform one iteration per cycle for exactly 32 cycles (counter 0..31), then enter FIX.
REQ-015 Multiply SHALL use shift-add on operand magnitudes, giving a 64-bit unsigned product.
REQ-016 Divide SHALL use restoring division on magnitudes, giving a 32-bit quotient and a 32-bit remainder.
REQ-017 Magnitudes SHALL be two's-complement absolute values when is_unsigned=0, and the raw operands otherwise.
REQ-018 FIX (1 cycle) SHALL apply signs and register result:
  - signed multiply: product negated if a[31]^b[31];
  - signed divide: quotient negated if a[31]^b[31]; remainder takes the sign of a.
REQ-019 Divide packing SHALL be result[63:32] = remainder and result[31:0] = quotient.
REQ-020 DONE SHALL assert done=1 and busy=0 for one cycle, then return to IDLE.
REQ-021 Total latency SHALL be fixed: done at cycle N+34 for every operation, including b == 0.
REQ-022 Divide by zero SHALL give quotient 32'hFFFFFFFF and remainder = a (raw), with div_by_zero=1 in DONE.
REQ-023 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000, remainder 0, and no flag.
REQ-024 start SHALL be ignored in CALC, FIX and DONE; it causes no queueing and no corruption.
REQ-025 result SHALL change only on the FIX-to-DONE edge; div_by_zero SHALL be 0 outside DONE.

Reset
REQ-026 rst SHALL force state IDLE, busy=0, done=0, div_by_zero=0, result=0, counter=0, and clear all operand registers.
REQ-027 rst during CALC or FIX SHALL abort the operation; no done pulse follows.

Configuration
REQ-028 Macro MULT_DIV_SEQ_DIV_EN: when defined, divide hardware is compiled in and behaves per REQ-016..REQ-023.
REQ-029 Without MULT_DIV_SEQ_DIV_EN, a start with is_mult=0 SHALL go IDLE to DONE in one cycle (done at N+1) with result=0 and div_by_zero=0; multiply behaviour is unchanged.

Structure
REQ-030 Shared package mdu_pkg SHALL hold:
  - the state enum;
  - MDU_ITER = 32;
  - MDU_LATENCY = 34;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
REQ-031 Sign pre-conditioning and post-fix SHALL sit in one combinational sub-module, mdu_sign_fix; iteration datapath and FSM stay in mult_div_seq.

Verification
REQ-032 Signed multiply: a=32'hFFFFFFFD (-3), b=5 -> done at N+34, result=64'hFFFFFFFF_FFFFFFF1.
REQ-033 Unsigned multiply: a=b=32'hFFFFFFFF -> result=64'hFFFFFFFE_00000001.
REQ-034 Signed divide: a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, div_by_zero=0.
REQ-035 Unsigned divide by zero: a=7, b=0 -> lo=32'hFFFFFFFF, hi=7, div_by_zero=1 for one cycle at N+34.
REQ-036 Start ignored while busy: second start at N+5 with different operands -> first result unchanged, exactly one done.
REQ-037 Reset mid-operation: rst at N+10 -> busy=0 at once, result=0, no done; a new start then completes normally at +34.
